// File: rtl/hazard_unit_pkg.sv
// ---------------------------------------------------------------------------
// hazard_unit_pkg -- ISA definitions shared by the pipeline control logic.
//
// Contents:
//   RCNT_LOG        register-address width (32 architectural registers)
//   opcode_t        major opcodes of the integer ISA
//   LOAD_OPCODE     opcode that produces a load-use dependency
//   hazard_state_t  hazard controller FSM states (RUN / DWAIT)
//   src_hits_rd()   helper: does a used decode source read a live rd
// ---------------------------------------------------------------------------
package hazard_unit_pkg;

  localparam int unsigned RCNT_LOG = 5;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'h03,
    OP_IMM    = 7'h13,
    OP_AUIPC  = 7'h17,
    OP_STORE  = 7'h23,
    OP_OP     = 7'h33,
    OP_LUI    = 7'h37,
    OP_BRANCH = 7'h63,
    OP_JALR   = 7'h67,
    OP_JAL    = 7'h6F
  } opcode_t;

  localparam opcode_t LOAD_OPCODE = OP_LOAD;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DWAIT = 1'b1
  } hazard_state_t;

  // x0 is hard-wired to zero, so a load targeting it never creates a dependency.
  function automatic logic src_hits_rd(input logic                uses,
                                       input logic [RCNT_LOG-1:0] src,
                                       input logic [RCNT_LOG-1:0] rd);
    logic hit;
    hit = uses && (rd != {RCNT_LOG{1'b0}}) && (src == rd);
    return hit;
  endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// ---------------------------------------------------------------------------
// hazard_perf_cnt -- saturating stall-cycle counter.
//
// Ports:
//   clk    in   pipeline clock
//   rst    in   synchronous active-high reset, clears the count
//   inc    in   count this cycle
//   count  out  PERF_W-bit registered count, sticks at all-ones
// ---------------------------------------------------------------------------
module hazard_perf_cnt #(
  parameter int unsigned PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  output logic [PERF_W-1:0] count
);

  logic [PERF_W-1:0] count_r;
  logic [PERF_W-1:0] count_nxt_s;

  // Next count: hold at all-ones instead of wrapping back to zero.
  always_comb begin
    count_nxt_s = count_r;
    if (inc && (count_r != {PERF_W{1'b1}})) begin
      count_nxt_s = count_r + {{(PERF_W-1){1'b0}}, 1'b1};
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Count register with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {PERF_W{1'b0}};
    end else begin
      count_r <= count_nxt_s;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/hazard_unit.sv
// ---------------------------------------------------------------------------
// hazard_unit -- pipeline hazard controller for a 5-stage in-order core.
//
// Detects data-memory wait, branch flush, load-use and fetch-miss hazards and
// drives the stage stall / NOP-insert controls in the same cycle the hazard
// is seen. Priority: memory wait > branch flush > load-use > fetch miss.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   id_rs1_addr, id_rs2_addr      decode source registers
//   id_uses_rs1, id_uses_rs2      decode actually reads rs1 / rs2
//   ex_opcode, ex_rd_addr         execute-stage opcode and destination
//   ex_branch_taken               execute resolved a taken branch / jump
//   imem_ack                      instruction word valid
//   dmem_req, dmem_ack            data access request / completion
//   fetch/decode/execute/memory_stall   hold pipeline registers
//   decode/execute/writeback_nop  load NOP into pipeline registers
//   dwait                         controller is in DWAIT
//   stall_cycles                  fetch-stall counter (HAZARD_PERF_EN only)
//
// Build option: define HAZARD_PERF_EN to add the stall_cycles counter.
// ---------------------------------------------------------------------------
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int unsigned PERF_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [RCNT_LOG-1:0] id_rs1_addr,
  input  logic [RCNT_LOG-1:0] id_rs2_addr,
  input  logic                id_uses_rs1,
  input  logic                id_uses_rs2,
  input  opcode_t             ex_opcode,
  input  logic [RCNT_LOG-1:0] ex_rd_addr,
  input  logic                ex_branch_taken,
  input  logic                imem_ack,
  input  logic                dmem_req,
  input  logic                dmem_ack,
  output logic                fetch_stall,
  output logic                decode_stall,
  output logic                execute_stall,
  output logic                memory_stall,
  output logic                decode_nop,
  output logic                execute_nop,
  output logic                writeback_nop,
  output logic                dwait
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_W-1:0]   stall_cycles
`endif
);

  hazard_state_t state_r;
  hazard_state_t state_nxt_s;
  logic          br_pend_r;
  logic          br_pend_nxt_s;
  logic          mem_wait_s;
  logic          load_use_s;
  logic          flush_s;

  // Memory wait covers the first missed cycle (still in RUN) and all of DWAIT.
  assign mem_wait_s = (state_r == ST_DWAIT) || (dmem_req && !dmem_ack);

  assign load_use_s = (ex_opcode == LOAD_OPCODE) &&
                      (src_hits_rd(id_uses_rs1, id_rs1_addr, ex_rd_addr) ||
                       src_hits_rd(id_uses_rs2, id_rs2_addr, ex_rd_addr));

  // A branch seen during a wait is remembered so it flushes exactly once
  // after the wait, even if execute no longer reports it then.
  assign flush_s = ex_branch_taken || br_pend_r;

  // FSM next state.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (dmem_req && !dmem_ack) begin
          state_nxt_s = ST_DWAIT;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DWAIT: begin
        if (dmem_ack) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_DWAIT;
        end
      end
      default: state_nxt_s = ST_RUN;
    endcase
  end

  // Deferred-branch flag: accumulate while waiting, consumed on the first free cycle.
  always_comb begin
    br_pend_nxt_s = 1'b0;
    if (mem_wait_s) begin
      br_pend_nxt_s = br_pend_r || ex_branch_taken;
    end else begin
      br_pend_nxt_s = 1'b0;
    end
  end

  // State registers; reset wins over any pending memory acknowledge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_RUN;
      br_pend_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      br_pend_r <= br_pend_nxt_s;
    end
  end

  // Hazard response, highest priority first.
  always_comb begin
    fetch_stall   = 1'b0;
    decode_stall  = 1'b0;
    execute_stall = 1'b0;
    memory_stall  = 1'b0;
    decode_nop    = 1'b0;
    execute_nop   = 1'b0;
    writeback_nop = 1'b0;
    if (mem_wait_s) begin
      fetch_stall   = 1'b1;
      decode_stall  = 1'b1;
      execute_stall = 1'b1;
      memory_stall  = 1'b1;
      writeback_nop = 1'b1;
    end else if (flush_s) begin
      decode_nop  = 1'b1;
      execute_nop = 1'b1;
    end else if (load_use_s) begin
      fetch_stall  = 1'b1;
      decode_stall = 1'b1;
      execute_nop  = 1'b1;
    end else if (!imem_ack) begin
      fetch_stall = 1'b1;
      decode_nop  = 1'b1;
    end else begin
      fetch_stall = 1'b0;
    end
  end

  assign dwait = (state_r == ST_DWAIT);

`ifdef HAZARD_PERF_EN
  hazard_perf_cnt #(
    .PERF_W (PERF_W)
  ) u_perf_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (fetch_stall),
    .count (stall_cycles)
  );
`endif

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;
  import hazard_unit_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [RCNT_LOG-1:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic                id_uses_rs1, id_uses_rs2;
  opcode_t             ex_opcode;
  logic                ex_branch_taken, imem_ack, dmem_req, dmem_ack;
  logic fetch_stall, decode_stall, execute_stall, memory_stall;
  logic decode_nop, execute_nop, writeback_nop, dwait;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles;
`endif

  hazard_unit #(.PERF_W(32)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_opcode(ex_opcode), .ex_rd_addr(ex_rd_addr),
    .ex_branch_taken(ex_branch_taken), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .fetch_stall(fetch_stall), .decode_stall(decode_stall),
    .execute_stall(execute_stall), .memory_stall(memory_stall),
    .decode_nop(decode_nop), .execute_nop(execute_nop),
    .writeback_nop(writeback_nop), .dwait(dwait)
`ifdef HAZARD_PERF_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  // {fetch_stall, decode_stall, execute_stall, memory_stall, decode_nop, execute_nop, writeback_nop, dwait}
  logic [7:0] dut_out;
  assign dut_out = {fetch_stall, decode_stall, execute_stall, memory_stall,
                    decode_nop, execute_nop, writeback_nop, dwait};

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  bit          m_in_dwait = 1'b0;
  bit          m_owed_flush = 1'b0;
  logic [31:0] m_cnt = 32'd0;

  opcode_t ops [4] = '{OP_LOAD, OP_OP, OP_IMM, OP_STORE};

  function automatic bit model_load_use();
    bit rs1_dep, rs2_dep;
    if (ex_opcode != OP_LOAD || ex_rd_addr == 5'd0) return 1'b0;
    rs1_dep = id_uses_rs1 && (id_rs1_addr == ex_rd_addr);
    rs2_dep = id_uses_rs2 && (id_rs2_addr == ex_rd_addr);
    return rs1_dep || rs2_dep;
  endfunction

  function automatic logic [7:0] model_out();
    bit waiting;
    waiting = m_in_dwait || (dmem_req && !dmem_ack);
    if (waiting)                          return {7'b1111_001, m_in_dwait};
    if (ex_branch_taken || m_owed_flush)  return 8'b0000_1100;
    if (model_load_use())                 return 8'b1100_0100;
    if (!imem_ack)                        return 8'b1000_1000;
    return 8'b0000_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Explicit literal check in the current cycle (before the active edge).
  task automatic peek(input string tag, input logic [7:0] exp);
    #1;
    check(tag, {24'd0, dut_out}, {24'd0, exp});
  endtask

  // Check against the model, then advance one clock and the model with it.
  task automatic cycle(input string tag);
    logic [7:0] exp;
    bit waiting, nxt_dwait, nxt_owed;
    logic [31:0] nxt_cnt;
    #1;
    exp = model_out();
    check({tag, ":out"}, {24'd0, dut_out}, {24'd0, exp});
`ifdef HAZARD_PERF_EN
    check({tag, ":cnt"}, stall_cycles, m_cnt);
`endif
    waiting = m_in_dwait || (dmem_req && !dmem_ack);
    if (rst) begin
      nxt_dwait = 1'b0; nxt_owed = 1'b0; nxt_cnt = 32'd0;
    end else begin
      nxt_dwait = m_in_dwait ? !dmem_ack : (dmem_req && !dmem_ack);
      nxt_owed  = waiting && (m_owed_flush || ex_branch_taken);
      nxt_cnt   = (exp[7] && m_cnt != 32'hFFFF_FFFF) ? m_cnt + 32'd1 : m_cnt;
    end
    @(posedge clk);
    m_in_dwait = nxt_dwait; m_owed_flush = nxt_owed; m_cnt = nxt_cnt;
    @(negedge clk);
  endtask

  task automatic set_idle();
    rst = 1'b0; dmem_req = 1'b0; dmem_ack = 1'b0; ex_branch_taken = 1'b0;
    imem_ack = 1'b1; ex_opcode = OP_OP; ex_rd_addr = 5'd0;
    id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
  endtask

  initial begin
    set_idle();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    peek("reset_outputs", 8'b0000_0000);
    cycle("reset");
    set_idle();
    cycle("idle");

    // Load x5 in execute, decode add x6,x5,x1.
    ex_opcode = OP_LOAD; ex_rd_addr = 5'd5;
    id_rs1_addr = 5'd5; id_rs2_addr = 5'd1; id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1;
    peek("load_use", 8'b1100_0100);
    cycle("load_use");
    set_idle();
    peek("load_use_after", 8'b0000_0000);
    cycle("load_use_after");

    // Data memory wait: ack low for 3 cycles.
    dmem_req = 1'b1;
    peek("dwait_c0", 8'b1111_0010);
    cycle("dwait_c0");
    peek("dwait_c1", 8'b1111_0011);
    cycle("dwait_c1");
    peek("dwait_c2", 8'b1111_0011);
    cycle("dwait_c2");
    dmem_ack = 1'b1;
    peek("dwait_ack", 8'b1111_0011);
    cycle("dwait_ack");
    set_idle();
    peek("dwait_after", 8'b0000_0000);
    cycle("dwait_after");

    // Branch coincident with load-use: flush wins, no fetch stall.
    ex_opcode = OP_LOAD; ex_rd_addr = 5'd3; id_rs1_addr = 5'd3; id_uses_rs1 = 1'b1;
    ex_branch_taken = 1'b1;
    peek("br_over_lu", 8'b0000_1100);
    cycle("br_over_lu");
    set_idle();

    // Branch taken while ack low for 2 cycles: one deferred flush.
    dmem_req = 1'b1; ex_branch_taken = 1'b1;
    peek("br_wait_c0", 8'b1111_0010);
    cycle("br_wait_c0");
    ex_branch_taken = 1'b0;
    peek("br_wait_c1", 8'b1111_0011);
    cycle("br_wait_c1");
    dmem_ack = 1'b1;
    cycle("br_wait_ack");
    set_idle();
    peek("br_deferred_flush", 8'b0000_1100);
    cycle("br_deferred_flush");
    peek("br_flush_once", 8'b0000_0000);
    cycle("br_flush_once");

    // Fetch miss.
    imem_ack = 1'b0;
    peek("fetch_miss", 8'b1000_1000);
    cycle("fetch_miss");
    set_idle();

    // Load x0 with decode reading x0: no stall.
    ex_opcode = OP_LOAD; ex_rd_addr = 5'd0; id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1;
    peek("x0_no_stall", 8'b0000_0000);
    cycle("x0_no_stall");
    set_idle();

    // Reset while in DWAIT, ack still low.
    dmem_req = 1'b1;
    cycle("pre_rst_c0");
    cycle("pre_rst_c1");
    rst = 1'b1;
    cycle("rst_in_dwait");
    set_idle();
    peek("after_rst_dwait", 8'b0000_0000);
`ifdef HAZARD_PERF_EN
    check("after_rst_cnt", stall_cycles, 32'd0);
`endif
    cycle("after_rst_dwait");

    // Exactly five stall cycles.
    imem_ack = 1'b0;
    for (int i = 0; i < 5; i++) cycle("five_stalls");
    set_idle();
`ifdef HAZARD_PERF_EN
    #1;
    check("five_stall_cnt", stall_cycles, 32'd5);
`endif
    cycle("after_five");

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rst             = ($urandom_range(0, 99) < 2);
      dmem_req        = ($urandom_range(0, 99) < 30);
      dmem_ack        = ($urandom_range(0, 99) < 50);
      ex_branch_taken = ($urandom_range(0, 99) < 15);
      imem_ack        = ($urandom_range(0, 99) < 80);
      ex_opcode       = ops[$urandom_range(0, 3)];
      ex_rd_addr      = 5'($urandom_range(0, 3));
      id_rs1_addr     = 5'($urandom_range(0, 3));
      id_rs2_addr     = 5'($urandom_range(0, 3));
      id_uses_rs1     = 1'($urandom_range(0, 1));
      id_uses_rs2     = 1'($urandom_range(0, 1));
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
